// File: rtl/time_announce_if.sv
// time_announce_if: request/alarm inputs and playlist/status outputs of the time announcer.
//   master: drives announce_req, hourly_mode, hour, minute, alarm_fire, alarm_ack
//   slave : drives playlist_no, aud_en, alarm_en, alarm_beep, busy, done, err
interface time_announce_if;
   logic        announce_req;
   logic        hourly_mode;
   logic [4:0]  hour;
   logic [5:0]  minute;
   logic        alarm_fire;
   logic        alarm_ack;
   logic [19:0] playlist_no;
   logic        aud_en;
   logic        alarm_en;
   logic        alarm_beep;
   logic        busy;
   logic        done;
   logic        err;
   modport master (
      output announce_req, hourly_mode, hour, minute, alarm_fire, alarm_ack,
      input  playlist_no, aud_en, alarm_en, alarm_beep, busy, done, err
   );
   modport slave (
      input  announce_req, hourly_mode, hour, minute, alarm_fire, alarm_ack,
      output playlist_no, aud_en, alarm_en, alarm_beep, busy, done, err
   );
endinterface

// File: rtl/time_announce_ctrl.sv
// time_announce_ctrl: speaks the time as a clip playlist and runs a self-stopping alarm tone.
//   clk      : system clock, rising edge
//   sysreset : synchronous active-low reset
//   bus      : time_announce_if.slave (requests in, playlist/enables/status out)
module time_announce_ctrl #(
   parameter int CLIP_CYCLES = 100000000,
   parameter int BEEP_CYCLES = 50000000,
   parameter int ALARM_BEEPS = 60
) (
   input logic           clk,
   input logic           sysreset,
   time_announce_if.slave bus
);
   localparam int CW = $clog2(4 * CLIP_CYCLES + 1);
   localparam int HW = $clog2(BEEP_CYCLES + 1);
   localparam int PW = $clog2(ALARM_BEEPS + 1);
   typedef enum logic [2:0] {IDLE, LOAD, PLAY, DONE, ALARM} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt, play_last;
   logic [HW-1:0] hcnt;
   logic [PW-1:0] pcnt;
   logic          beep, err_q, valid, half_end, beep_end;
   logic [19:0]   playlist;
   logic [4:0]    hr_m, hr_code, tens_code, unit_code, ap_code;
   always_comb begin
      valid     = bus.hour <= 5'd23 && bus.minute <= 6'd59;
      hr_m      = bus.hour >= 5'd12 ? bus.hour - 5'd12 : bus.hour;
      hr_code   = hr_m == 5'd0 ? 5'd12 : hr_m;
      tens_code = (bus.minute == 6'd0 || bus.hourly_mode) ? 5'd20 :
                  bus.minute < 6'd10 ? 5'd28 : 5'(6'd20 + bus.minute / 6'd10);
      unit_code = (bus.hourly_mode || bus.minute % 6'd10 == 6'd0) ? 5'd0 : 5'(bus.minute % 6'd10);
      ap_code   = bus.hour < 5'd12 ? 5'd26 : 5'd27;
      // only the units word can be skipped, so a playlist is three or four clips long
      play_last = playlist[14:10] != 5'd0 ? CW'(4 * CLIP_CYCLES - 1) : CW'(3 * CLIP_CYCLES - 1);
      half_end  = hcnt == HW'(BEEP_CYCLES - 1);
      // a full period ends at the last cycle of the low half
      beep_end  = half_end && !beep && pcnt == PW'(ALARM_BEEPS - 1);
   end
   always_ff @(posedge clk)
      if (!sysreset) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.announce_req && valid ? LOAD : IDLE;
         LOAD:    nxt = PLAY;
         PLAY:    nxt = cnt == play_last ? DONE : PLAY;
         DONE:    nxt = IDLE;
         ALARM:   nxt = bus.alarm_ack || beep_end ? IDLE : ALARM;
         default: nxt = IDLE;
      endcase
      if (bus.alarm_fire && state != ALARM) nxt = ALARM;
   end
   always_comb begin
      bus.playlist_no = playlist;
      bus.aud_en      = state == PLAY;
      bus.alarm_en    = state == ALARM;
      bus.alarm_beep  = state == ALARM && beep;
      bus.busy        = state != IDLE;
      bus.done        = state == DONE;
      bus.err         = err_q;
   end
   always_ff @(posedge clk)
      if (!sysreset) begin
         playlist <= '0;
         cnt      <= '0;
         hcnt     <= '0;
         pcnt     <= '0;
         beep     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= state == IDLE && bus.announce_req && !valid && !bus.alarm_fire;
         if (state == LOAD) playlist <= {ap_code, unit_code, tens_code, hr_code};
         cnt <= state == PLAY && nxt == PLAY ? cnt + CW'(1) : '0;
         // beep is preloaded high outside ALARM so the entry cycle sounds
         if (state != ALARM) begin
            hcnt <= '0;
            pcnt <= '0;
            beep <= 1'b1;
         end else if (half_end) begin
            hcnt <= '0;
            beep <= ~beep;
            pcnt <= pcnt + PW'(!beep);
         end else hcnt <= hcnt + HW'(1);
      end
endmodule

// File: tb/tb_time_announce_ctrl.sv
// tb_time_announce_ctrl: directed self-checking bench for time_announce_ctrl.
module tb_time_announce_ctrl;
   logic clk = 1'b0;
   logic sysreset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   time_announce_if bus();
   time_announce_ctrl #(.CLIP_CYCLES(10), .BEEP_CYCLES(4), .ALARM_BEEPS(6)) dut (
      .clk(clk), .sysreset(sysreset), .bus(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   function automatic logic [19:0] pl(input logic [4:0] ap, u, t, h);
      return {ap, u, t, h};
   endfunction
   function automatic logic [5:0] outs();
      return {bus.aud_en, bus.alarm_en, bus.alarm_beep, bus.busy, bus.done, bus.err};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic start(input logic [4:0] h, input logic [5:0] m, input logic mode);
      bus.hour = h;
      bus.minute = m;
      bus.hourly_mode = mode;
      bus.announce_req = 1'b1;
      tick();
      bus.announce_req = 1'b0;
      tick();
   endtask
   task automatic announce(input string name, input logic [4:0] h, input logic [5:0] m,
                           input logic mode, input logic [19:0] exp, input int len);
      int n;
      bus.hour = h;
      bus.minute = m;
      bus.hourly_mode = mode;
      bus.announce_req = 1'b1;
      tick();
      bus.announce_req = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.aud_en !== 1'b0) begin
         failures++;
         $display("FAIL %s_load: busy=%b aud_en=%b expected busy=1 aud_en=0", name, bus.busy, bus.aud_en);
      end
      tick();
      checks++;
      if (bus.playlist_no !== exp) begin
         failures++;
         $display("FAIL %s_playlist: got %h expected %h", name, bus.playlist_no, exp);
      end
      n = 0;
      while (bus.aud_en === 1'b1 && n < 500) begin
         n++;
         tick();
      end
      checks++;
      if (n != len) begin
         failures++;
         $display("FAIL %s_aud_len: got %0d expected %0d", name, n, len);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.alarm_en !== 1'b0) begin
         failures++;
         $display("FAIL %s_done: done=%b alarm_en=%b expected done=1 alarm_en=0", name, bus.done, bus.alarm_en);
      end
      tick();
      checks++;
      if (outs() !== 6'b0 || bus.playlist_no !== exp) begin
         failures++;
         $display("FAIL %s_idle: outs=%b playlist=%h expected outs=000000 playlist=%h", name, outs(), bus.playlist_no, exp);
      end
   endtask
   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if (outs() !== 6'b0 || bus.playlist_no !== 20'h0) begin
         failures++;
         $display("FAIL reset: outs=%b playlist=%h expected all 0", outs(), bus.playlist_no);
      end
      sysreset = 1'b1;
      tick();
   endtask
   task automatic test_err(input string name, input logic [4:0] h, input logic [5:0] m, input logic [19:0] keep);
      bus.hour = h;
      bus.minute = m;
      bus.hourly_mode = 1'b0;
      bus.announce_req = 1'b1;
      tick();
      bus.announce_req = 1'b0;
      checks++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_pulse: err=%b busy=%b expected err=1 busy=0", name, bus.err, bus.busy);
      end
      tick();
      checks++;
      if (outs() !== 6'b0 || bus.playlist_no !== keep) begin
         failures++;
         $display("FAIL %s_after: outs=%b playlist=%h expected outs=000000 playlist=%h", name, outs(), bus.playlist_no, keep);
      end
   endtask
   task automatic test_alarm_abort();
      int k, bad;
      logic saw_done;
      start(5'd13, 6'd45, 1'b0);
      bus.hour = 5'd24;
      bus.announce_req = 1'b1;
      tick();
      bus.announce_req = 1'b0;
      checks++;
      if (bus.err !== 1'b0 || bus.aud_en !== 1'b1) begin
         failures++;
         $display("FAIL req_in_play: err=%b aud_en=%b expected err=0 aud_en=1", bus.err, bus.aud_en);
      end
      repeat (13) tick();
      bus.alarm_fire = 1'b1;
      tick();
      bus.alarm_fire = 1'b0;
      checks++;
      if (bus.aud_en !== 1'b0 || bus.alarm_en !== 1'b1 || bus.alarm_beep !== 1'b1 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL abort_entry: outs=%b expected 011100", outs());
      end
      k = 0;
      bad = 0;
      saw_done = 1'b0;
      while (bus.alarm_en === 1'b1 && k < 200) begin
         if (bus.alarm_beep !== ((k / 4) % 2 == 0)) bad++;
         if (bus.done === 1'b1 || bus.aud_en === 1'b1) saw_done = 1'b1;
         k++;
         tick();
      end
      checks++;
      if (k != 48) begin
         failures++;
         $display("FAIL alarm_len: got %0d expected 48", k);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL beep_pattern: got %0d wrong cycles expected 0", bad);
      end
      checks++;
      if (saw_done !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_done: got done/aud_en during alarm expected none");
      end
      checks++;
      if (outs() !== 6'b0) begin
         failures++;
         $display("FAIL alarm_auto_stop: outs=%b expected 000000", outs());
      end
   endtask
   task automatic test_alarm_ack();
      bus.alarm_fire = 1'b1;
      tick();
      bus.alarm_fire = 1'b0;
      checks++;
      if (bus.alarm_en !== 1'b1 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL ack_entry: alarm_en=%b busy=%b expected 1 1", bus.alarm_en, bus.busy);
      end
      repeat (5) tick();
      bus.alarm_ack = 1'b1;
      tick();
      bus.alarm_ack = 1'b0;
      checks++;
      if (outs() !== 6'b0) begin
         failures++;
         $display("FAIL ack_stop: outs=%b expected 000000", outs());
      end
      announce("after_ack", 5'd9, 6'd7, 1'b1, pl(5'd26, 5'd0, 5'd20, 5'd9), 30);
   endtask
   task automatic test_back_to_back(input logic [19:0] keep);
      bus.hour = 5'd13;
      bus.minute = 6'd45;
      bus.hourly_mode = 1'b0;
      bus.announce_req = 1'b1;
      bus.alarm_fire = 1'b1;
      tick();
      bus.announce_req = 1'b0;
      bus.alarm_fire = 1'b0;
      checks++;
      if (bus.alarm_en !== 1'b1 || bus.aud_en !== 1'b0) begin
         failures++;
         $display("FAIL fire_and_req: alarm_en=%b aud_en=%b expected 1 0", bus.alarm_en, bus.aud_en);
      end
      bus.alarm_ack = 1'b1;
      tick();
      bus.alarm_ack = 1'b0;
      tick();
      checks++;
      if (outs() !== 6'b0 || bus.playlist_no !== keep) begin
         failures++;
         $display("FAIL req_dropped: outs=%b playlist=%h expected outs=000000 playlist=%h", outs(), bus.playlist_no, keep);
      end
   endtask
   task automatic test_reset_mid_play();
      start(5'd13, 6'd45, 1'b0);
      repeat (5) tick();
      sysreset = 1'b0;
      tick();
      checks++;
      if (outs() !== 6'b0 || bus.playlist_no !== 20'h0) begin
         failures++;
         $display("FAIL reset_mid_play: outs=%b playlist=%h expected all 0", outs(), bus.playlist_no);
      end
      sysreset = 1'b1;
      tick();
      announce("post_reset", 5'd0, 6'd0, 1'b0, pl(5'd26, 5'd0, 5'd20, 5'd12), 30);
   endtask
   initial begin
      bus.announce_req = 1'b0;
      bus.hourly_mode = 1'b0;
      bus.hour = 5'd0;
      bus.minute = 6'd0;
      bus.alarm_fire = 1'b0;
      bus.alarm_ack = 1'b0;
      test_reset();
      announce("t1345", 5'd13, 6'd45, 1'b0, pl(5'd27, 5'd5, 5'd24, 5'd1), 40);
      announce("t0000", 5'd0, 6'd0, 1'b0, pl(5'd26, 5'd0, 5'd20, 5'd12), 30);
      announce("t0907h", 5'd9, 6'd7, 1'b1, pl(5'd26, 5'd0, 5'd20, 5'd9), 30);
      announce("t2303", 5'd23, 6'd3, 1'b0, pl(5'd27, 5'd3, 5'd28, 5'd11), 40);
      test_err("hour24", 5'd24, 6'd0, pl(5'd27, 5'd3, 5'd28, 5'd11));
      test_err("min60", 5'd5, 6'd60, pl(5'd27, 5'd3, 5'd28, 5'd11));
      test_alarm_abort();
      test_alarm_ack();
      test_back_to_back(pl(5'd26, 5'd0, 5'd20, 5'd9));
      test_reset_mid_play();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/time_announce_ctrl.md
TIME_ANNOUNCE_CTRL -- requirements
Module: time_announce_ctrl

Interface
REQ-001 Parameter CLIP_CYCLES, default 100000000: clock cycles of audio time allotted per non-zero playlist field.
REQ-002 Parameter BEEP_CYCLES, default 50000000: cycles per alarm_beep half-period.
REQ-003 Parameter ALARM_BEEPS, default 60: full beep periods before alarm auto-stop.
REQ-004 clk  in  1  single system clock (100 MHz); all logic on its rising edge.
REQ-005 sysreset  in  1  reset, synchronous, active-low.
REQ-006 announce_req  in  1  one-cycle request to speak the current time.
REQ-007 hourly_mode  in  1  sampled with announce_req; 1 = speak hour only.
REQ-008 hour  in  5  current hour, 0-23.
REQ-009 minute  in  6  current minute, 0-59.
REQ-010 alarm_fire  in  1  one-cycle alarm trigger.
REQ-011 alarm_ack  in  1  level; user stop for the alarm.
REQ-012 playlist_no  out  20  clip codes: [4:0] hour word, [9:5] minute-tens word, [14:10] minute-units word, [19:15] AM/PM word.
REQ-013 aud_en  out  1  voice playback enable; selects the voice path when high.
REQ-014 alarm_en  out  1  alarm tone enable.
REQ-015 alarm_beep  out  1  alarm tone gate.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse at the end of an announcement.
REQ-018 err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, PLAY, DONE and ALARM.
REQ-020 IDLE + announce_req with hour<=23 and minute<=59 -> LOAD; out-of-range inputs -> err pulse next cycle, remain in IDLE, playlist_no unchanged.
REQ-021 LOAD: register playlist_no in one cycle, then -> PLAY; hour, minute and hourly_mode are captured only here.
REQ-022 Hour field: h = hour mod 12, code = 12 if h==0, else h.
REQ-023 Tens field: code 20 ("o'clock") if minute==0 or hourly_mode; code 28 ("oh") if minute 1-9; else 20+minute/10 (21-25).
REQ-024 Units field: code 0 (skip) if hourly_mode or minute mod 10 == 0; else minute mod 10.
REQ-025 AM/PM field: 26 if hour<12, else 27.
REQ-026 PLAY: aud_en=1 for exactly N*CLIP_CYCLES cycles, where N = count of non-zero fields (3 or 4); then -> DONE.
REQ-027 DONE: aud_en=0, done=1 for one cycle, then -> IDLE; playlist_no holds its last value.
REQ-028 alarm_fire in any state except ALARM -> ALARM on the next edge, aborting any announcement (aud_en=0 immediately, no done pulse); alarm_fire in ALARM is ignored.
REQ-029 alarm_fire and announce_req in the same cycle: alarm wins and the request is dropped.
REQ-030 announce_req outside IDLE SHALL be ignored (no err).
REQ-031 ALARM: alarm_en=1; alarm_beep=1 on the entry cycle and toggles every BEEP_CYCLES cycles.
REQ-032 ALARM exits to IDLE the cycle after alarm_ack is sampled high, or after ALARM_BEEPS full periods; alarm_en and alarm_beep are 0 from that cycle on.
REQ-033 aud_en and alarm_en SHALL never be high together.
REQ-034 Counters SHALL be sized to hold 4*CLIP_CYCLES and ALARM_BEEPS without overflow.

Reset
REQ-035 sysreset low at a clock edge -> IDLE; playlist_no=0, aud_en=alarm_en=alarm_beep=busy=done=err=0, all counters 0, from the next cycle, including mid-PLAY or mid-ALARM.

Verification (CLIP_CYCLES=10, BEEP_CYCLES=4, ALARM_BEEPS=6)
REQ-036 hour=13, minute=45, hourly_mode=0, request -> playlist_no fields {27,5,24,1}; aud_en high 40 cycles; done pulse; busy low after.
REQ-037 hour=0, minute=0 -> fields {26,0,20,12}, aud_en 30 cycles; hour=9, minute=7, hourly_mode=1 -> {26,0,20,9}, 30 cycles.
REQ-038 hour=24 or minute=60 -> err pulse, busy stays 0, playlist_no unchanged.
REQ-039 alarm_fire at PLAY cycle 15 -> aud_en 0 and alarm_en 1 next cycle, no done; alarm_beep toggles every 4 cycles; no ack -> alarm_en drops after 48 cycles.
REQ-040 alarm_ack during ALARM -> alarm_en and alarm_beep 0 next cycle; a subsequent request is accepted.
REQ-041 sysreset low mid-PLAY -> all outputs 0 next cycle; after release, a new request runs normally.
